// File: rtl/tinyalu_exec.sv
// tinyalu_exec: execution core of the TinyALU.
// Takes a captured A/B/op command from the start/done handshake bus.
// Add, and and xor finish one cycle after capture.
// Unsigned 8x8 multiply runs through a MUL_STAGES-deep pipeline.
// Optional feature macro: TINYALU_ILLEGAL_OP_FLAG_EN adds a sticky illegal_op output.
// Without the macro, opcodes 101-111 behave exactly like no_op.
module tinyalu_exec #(
    parameter int MUL_STAGES = 3   // cycles from capture to done for mul, legal 2..6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
`ifdef TINYALU_ILLEGAL_OP_FLAG_EN
    output logic        illegal_op,
`endif
    output logic        busy
);

    // Opcode encoding on the command bus
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    // Handshake states
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EXEC     = 2'd1;
    localparam logic [1:0] S_MUL      = 2'd2;
    localparam logic [1:0] S_WAIT_LOW = 2'd3;

    // Counter value at which the multiply result is taken
    localparam logic [2:0] MUL_LAST = 3'(MUL_STAGES);

    // Full-product pipeline depth after the partial-product stage; kept at
    // least 1 so the array is never empty when MUL_STAGES is 2
    localparam int PROD_DEPTH = (MUL_STAGES > 2) ? (MUL_STAGES - 2) : 1;

    logic [1:0]  state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [15:0] result_q, result_d;

    logic [11:0] pp_lo_q, pp_lo_d;
    logic [11:0] pp_hi_q, pp_hi_d;
    logic [15:0] prod_q [PROD_DEPTH];
    logic [15:0] prod_d [PROD_DEPTH];

    logic [15:0] alu_res;
    logic [15:0] pp_sum;
    logic [15:0] mul_final;

    // Single-cycle operations on the captured operands
    always_comb begin
        alu_res = 16'h0000;
        case (op_q)
            OP_ADD:  alu_res = {7'b0, ({1'b0, a_q} + {1'b0, b_q})};
            OP_AND:  alu_res = {8'b0, (a_q & b_q)};
            OP_XOR:  alu_res = {8'b0, (a_q ^ b_q)};
            default: alu_res = 16'h0000;
        endcase
    end

    // Recombine the two nibble partial products into the full product
    assign pp_sum = {4'b0, pp_lo_q} + {pp_hi_q, 4'b0};

    // Multiply pipeline: stage 0 forms A*B[3:0] and A*B[7:4], later stages
    // carry the summed product; it only advances while a mul is in flight
    always_comb begin
        pp_lo_d = pp_lo_q;
        pp_hi_d = pp_hi_q;
        prod_d  = prod_q;
        if (state_q == S_MUL) begin
            pp_lo_d   = 12'(a_q) * 12'(b_q[3:0]);
            pp_hi_d   = 12'(a_q) * 12'(b_q[7:4]);
            prod_d[0] = pp_sum;
            for (int i = 1; i < PROD_DEPTH; i++) begin
                prod_d[i] = prod_q[i-1];
            end
        end
    end

    // Pick the pipeline tap that is valid on the edge the counter reaches MUL_STAGES
    generate
        if (MUL_STAGES == 2) begin : g_short_mul
            assign mul_final = pp_sum;
        end else begin : g_long_mul
            assign mul_final = prod_q[MUL_STAGES-3];
        end
    endgenerate

    // Handshake control: capture, completion, abort and wait-for-start-low
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d  = A;
                    b_d  = B;
                    op_d = op;
                    case (op)
                        OP_ADD, OP_AND, OP_XOR: state_d = S_EXEC;
                        OP_MUL: begin
                            state_d = S_MUL;
                            cnt_d   = 3'd1;
                        end
                        default: state_d = S_WAIT_LOW;
                    endcase
                end
            end
            S_EXEC: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = alu_res;
                    done_d   = 1'b1;
                    state_d  = S_WAIT_LOW;
                end
            end
            S_MUL: begin
                if (!start) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == MUL_LAST) begin
                    result_d = mul_final;
                    done_d   = 1'b1;
                    state_d  = S_WAIT_LOW;
                    cnt_d    = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WAIT_LOW: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers; reset discards any in-flight command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= OP_NOP;
            cnt_q    <= 3'd0;
            done_q   <= 1'b0;
            result_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Multiply pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pp_lo_q <= 12'h000;
            pp_hi_q <= 12'h000;
            for (int i = 0; i < PROD_DEPTH; i++) begin
                prod_q[i] <= 16'h0000;
            end
        end else begin
            pp_lo_q <= pp_lo_d;
            pp_hi_q <= pp_hi_d;
            for (int i = 0; i < PROD_DEPTH; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

`ifdef TINYALU_ILLEGAL_OP_FLAG_EN
    logic illegal_q, illegal_d;

    // Sticky flag raised when an opcode 101-111 is captured
    always_comb begin
        illegal_d = illegal_q;
        if ((state_q == S_IDLE) && start && (op > OP_MUL)) begin
            illegal_d = 1'b1;
        end
    end

    // Flag register, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
`endif

    assign done   = done_q;
    assign result = result_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_tinyalu_exec.sv
// tb_tinyalu_exec: randomized self-checking bench for tinyalu_exec.
// Expected results and latencies come from a plain arithmetic reference model.
// Honours TINYALU_ILLEGAL_OP_FLAG_EN to also check the sticky illegal_op flag.
module tb_tinyalu_exec;

    localparam int MUL_STAGES = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    logic        busy;
`ifdef TINYALU_ILLEGAL_OP_FLAG_EN
    logic        illegal_op;
    logic        model_flag = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_result = 16'h0000;

    tinyalu_exec #(.MUL_STAGES(MUL_STAGES)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .op     (op),
        .start  (start),
        .done   (done),
        .result (result),
`ifdef TINYALU_ILLEGAL_OP_FLAG_EN
        .illegal_op (illegal_op),
`endif
        .busy   (busy)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance past one rising edge and settle
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: arithmetic result of a legal operation
    function automatic logic [15:0] refResult(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        int v;
        case (o)
            3'd1:    v = a + b;
            3'd2:    v = a & b;
            3'd3:    v = a ^ b;
            3'd4:    v = a * b;
            default: v = 0;
        endcase
        return v[15:0];
    endfunction

    // Reference: cycles from capture to done, 0 when no done is issued
    function automatic int refLatency(input logic [2:0] o);
        if (o >= 3'd1 && o <= 3'd3) return 1;
        if (o == 3'd4) return MUL_STAGES;
        return 0;
    endfunction

    // Run one command through the handshake, optionally aborting it one cycle after capture
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                                 input int extra_hold, input bit abort);
        int          lat;
        logic [15:0] exp_res;
        lat     = refLatency(o);
        exp_res = refResult(a, b, o);
        A = a; B = b; op = o; start = 1'b1;
        tick();
`ifdef TINYALU_ILLEGAL_OP_FLAG_EN
        if (o > 3'd4) model_flag = 1'b1;
`endif
        A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
        checkOutput("busy_after_capture", 32'(busy), 32'd1);
        checkOutput("done_after_capture", 32'(done), 32'd0);
        if (abort && lat > 1) begin
            start = 1'b0;
            tick();
            checkOutput("abort_done", 32'(done), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_result", 32'(result), 32'(model_result));
            tick();
            checkOutput("abort_done_later", 32'(done), 32'd0);
            return;
        end
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (k < lat) begin
                checkOutput("done_early", 32'(done), 32'd0);
                checkOutput("busy_in_flight", 32'(busy), 32'd1);
                checkOutput("result_in_flight", 32'(result), 32'(model_result));
            end else begin
                model_result = exp_res;
                checkOutput("done_pulse", 32'(done), 32'd1);
                checkOutput("result_value", 32'(result), 32'(model_result));
            end
        end
        for (int k = 0; k < extra_hold; k++) begin
            tick();
            checkOutput("done_hold", 32'(done), 32'd0);
            checkOutput("busy_hold", 32'(busy), 32'd1);
            checkOutput("result_hold", 32'(result), 32'(model_result));
        end
        start = 1'b0;
        tick();
        checkOutput("done_release", 32'(done), 32'd0);
        checkOutput("busy_release", 32'(busy), 32'd0);
        checkOutput("result_release", 32'(result), 32'(model_result));
`ifdef TINYALU_ILLEGAL_OP_FLAG_EN
        checkOutput("illegal_flag", 32'(illegal_op), 32'(model_flag));
`endif
    endtask

    // Directed scenarios, then a randomized command stream
    initial begin
        reset = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; op = 3'd0;
        tick();
        tick();
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", 32'(result), 32'h0000);
        checkOutput("reset_busy", 32'(busy), 32'd0);
`ifdef TINYALU_ILLEGAL_OP_FLAG_EN
        checkOutput("reset_flag", 32'(illegal_op), 32'd0);
`endif
        reset = 1'b0;
        tick();

        applyStimulus(8'hFF, 8'hFF, 3'd1, 0, 1'b0);
        checkOutput("add_ff_ff", 32'(model_result), 32'h01FE);
        applyStimulus(8'hF0, 8'h3C, 3'd2, 0, 1'b0);
        checkOutput("and_f0_3c", 32'(result), 32'h0030);
        applyStimulus(8'hF0, 8'h3C, 3'd3, 2, 1'b0);
        checkOutput("xor_f0_3c", 32'(result), 32'h00CC);
        applyStimulus(8'hFF, 8'hFF, 3'd4, 1, 1'b0);
        checkOutput("mul_ff_ff", 32'(result), 32'hFE01);

        // no_op held for five cycles
        applyStimulus(8'h12, 8'h34, 3'd0, 4, 1'b0);
        checkOutput("nop_result", 32'(result), 32'hFE01);

        // mul aborted one cycle after capture
        applyStimulus(8'h0F, 8'h0F, 3'd4, 0, 1'b1);
        checkOutput("abort_keeps_old", 32'(result), 32'hFE01);

        // add aborted at its completion edge
        A = 8'h01; B = 8'h02; op = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("exec_abort_done", 32'(done), 32'd0);
        checkOutput("exec_abort_busy", 32'(busy), 32'd0);
        checkOutput("exec_abort_result", 32'(result), 32'hFE01);

        // reset asserted in the middle of a mul
        A = 8'h12; B = 8'h34; op = 3'd4; start = 1'b1;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        checkOutput("midmul_reset_done", 32'(done), 32'd0);
        checkOutput("midmul_reset_result", 32'(result), 32'h0000);
        checkOutput("midmul_reset_busy", 32'(busy), 32'd0);
        model_result = 16'h0000;
`ifdef TINYALU_ILLEGAL_OP_FLAG_EN
        model_flag = 1'b0;
`endif
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();

        // reset held across what would be a capture edge
        A = 8'h05; B = 8'h06; op = 3'd1; start = 1'b1; reset = 1'b1;
        tick();
        checkOutput("reset_vs_capture_busy", 32'(busy), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        checkOutput("reset_vs_capture_done", 32'(done), 32'd0);

`ifdef TINYALU_ILLEGAL_OP_FLAG_EN
        applyStimulus(8'h11, 8'h22, 3'd7, 1, 1'b0);
        checkOutput("flag_set", 32'(illegal_op), 32'd1);
        applyStimulus(8'h11, 8'h22, 3'd1, 0, 1'b0);
        checkOutput("flag_sticky", 32'(illegal_op), 32'd1);
        reset = 1'b1;
        #2;
        checkOutput("flag_cleared", 32'(illegal_op), 32'd0);
        model_flag = 1'b0;
        model_result = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        tick();
`endif

        // randomized command stream with occasional aborts and idle gaps
        for (int n = 0; n < 60; n++) begin
            applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 2) == 0) begin
                tick();
                checkOutput("idle_done", 32'(done), 32'd0);
                checkOutput("idle_busy", 32'(busy), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
